// File: rtl/ps2_entry_ctrl.sv
// PS/2 byte sequencer: strips F0/E0 prefixes, feeds make codes to the ASCII decoder and builds an entry line.
// Optional feature macro TYPEMATIC_FILTER_EN: suppress repeated make codes until a key release is seen.
module ps2_entry_ctrl #(
    parameter int MAX_LEN = 8,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_done_tick,
    input  logic [7:0]           rx_data,
    output logic [31:0]          scan_code,
    input  logic [7:0]           ascii_code,
    input  logic                 clear,
    output logic                 char_valid,
    output logic [7:0]           char_out,
    output logic [8*MAX_LEN-1:0] entry_buf,
    output logic [LW-1:0]        entry_len,
    output logic                 entry_done,
    output logic                 overflow
);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, DECODE} state_t;

    state_t     state;
    logic [7:0] slot [MAX_LEN];
    logic       take_action;

`ifdef TYPEMATIC_FILTER_EN
    logic [7:0] last_make;
    logic       suppress;

    assign take_action = (state == DECODE) && !clear && !entry_done && !suppress;
`else
    assign take_action = (state == DECODE) && !clear && !entry_done;
`endif

    always_comb begin
        entry_buf = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            entry_buf[i*8 +: 8] = slot[i];
        end
    end

    // A registered entry_done doubles as the commit trigger: the line stays visible for the pulse cycle, then clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            scan_code  <= '0;
            char_valid <= 1'b0;
            char_out   <= '0;
            entry_len  <= '0;
            entry_done <= 1'b0;
            overflow   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                slot[i] <= '0;
            end
`ifdef TYPEMATIC_FILTER_EN
            last_make  <= '0;
            suppress   <= 1'b0;
`endif
        end else begin
            char_valid <= 1'b0;
            entry_done <= 1'b0;
            overflow   <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_done_tick) begin
                        if (rx_data == 8'hF0) begin
                            state <= BREAK;
                        end else if (rx_data == 8'hE0) begin
                            state <= EXT;
                        end else begin
                            scan_code <= {24'h0, rx_data};
                            state     <= DECODE;
`ifdef TYPEMATIC_FILTER_EN
                            suppress  <= (rx_data == last_make);
                            last_make <= rx_data;
`endif
                        end
                    end
                end
                BREAK: begin
                    if (rx_done_tick) begin
                        state <= IDLE;
`ifdef TYPEMATIC_FILTER_EN
                        last_make <= '0;
`endif
                    end
                end
                EXT: begin
                    if (rx_done_tick) begin
                        state <= (rx_data == 8'hF0) ? BREAK : IDLE;
                    end
                end
                DECODE: begin
                    state <= IDLE;
                    if (take_action) begin
                        case (ascii_code)
                            8'h0D: begin
                                if (entry_len != '0) entry_done <= 1'b1;
                            end
                            8'h08: begin
                                if (entry_len != '0) begin
                                    for (int i = 0; i < MAX_LEN; i++) begin
                                        if (LW'(i) == entry_len - LW'(1)) slot[i] <= '0;
                                    end
                                    entry_len <= entry_len - LW'(1);
                                end
                            end
                            8'h2A, 8'h09: begin
                            end
                            default: begin
                                if (entry_len < LW'(MAX_LEN)) begin
                                    for (int i = 0; i < MAX_LEN; i++) begin
                                        if (LW'(i) == entry_len) slot[i] <= ascii_code;
                                    end
                                    entry_len  <= entry_len + LW'(1);
                                    char_out   <= ascii_code;
                                    char_valid <= 1'b1;
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase

            if (clear || entry_done) begin
                entry_len <= '0;
                for (int i = 0; i < MAX_LEN; i++) begin
                    slot[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_entry_ctrl.sv
// Self-checking bench for ps2_entry_ctrl with a small scan-code-to-ASCII decoder model.
// Build with TYPEMATIC_FILTER_EN defined to exercise the auto-repeat filter expectations.
module tb_ps2_entry_ctrl;

    localparam int MAX_LEN = 8;
    localparam int LW = $clog2(MAX_LEN + 1);

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 rx_done_tick = 1'b0;
    logic [7:0]           rx_data = 8'h00;
    logic [31:0]          scan_code;
    logic [7:0]           ascii_code;
    logic                 clear = 1'b0;
    logic                 char_valid;
    logic [7:0]           char_out;
    logic [8*MAX_LEN-1:0] entry_buf;
    logic [LW-1:0]        entry_len;
    logic                 entry_done;
    logic                 overflow;

    int checks = 0;
    int errors = 0;
    int cv_cnt = 0;
    int ov_cnt = 0;
    int done_cnt = 0;

    ps2_entry_ctrl #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .scan_code(scan_code), .ascii_code(ascii_code), .clear(clear),
        .char_valid(char_valid), .char_out(char_out), .entry_buf(entry_buf),
        .entry_len(entry_len), .entry_done(entry_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the external combinational decoder.
    always_comb begin
        case (scan_code[7:0])
            8'h16:   ascii_code = 8'h31;
            8'h1E:   ascii_code = 8'h32;
            8'h26:   ascii_code = 8'h33;
            8'h25:   ascii_code = 8'h34;
            8'h2E:   ascii_code = 8'h35;
            8'h36:   ascii_code = 8'h36;
            8'h3D:   ascii_code = 8'h37;
            8'h3E:   ascii_code = 8'h38;
            8'h46:   ascii_code = 8'h39;
            8'h45:   ascii_code = 8'h30;
            8'h1C:   ascii_code = 8'h61;
            8'h66:   ascii_code = 8'h08;
            8'h5A:   ascii_code = 8'h0D;
            8'h0D:   ascii_code = 8'h09;
            default: ascii_code = 8'h2A;
        endcase
    end

    always @(negedge clk) begin
        if (char_valid) cv_cnt++;
        if (overflow) ov_cnt++;
        if (entry_done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (scan_code !== 32'h0 || char_out !== 8'h0 || entry_buf !== '0 || entry_len !== '0) begin
            errors++;
            $display("[TB] FAIL reset_regs: scan=%h char_out=%h buf=%h len=%0d, required all 0", scan_code, char_out, entry_buf, entry_len);
        end
        checks++;
        if (char_valid !== 1'b0 || entry_done !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pulses: cv=%b done=%b ov=%b, required 0", char_valid, entry_done, overflow);
        end
    endtask

    task automatic test_basic_entry();
        int cv0;
        cv0 = cv_cnt;
        @(posedge clk); #1;
        rx_data = 8'h16;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        checks++;
        if (scan_code !== 32'h16 || char_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_scan_n1: scan=%h cv=%b, required 00000016 and 0", scan_code, char_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (char_valid !== 1'b1 || char_out !== 8'h31 || entry_len !== LW'(1)) begin
            errors++;
            $display("[TB] FAIL basic_pulse_n2: cv=%b char=%h len=%0d, required 1 31 1", char_valid, char_out, entry_len);
        end
        @(posedge clk); #1;
        checks++;
        if (char_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_pulse_width: cv=%b, required 0", char_valid);
        end
        send_byte(8'hF0); send_byte(8'h16);
        send_byte(8'h1E); send_byte(8'hF0); send_byte(8'h1E);
        checks++;
        if (cv_cnt - cv0 !== 2 || entry_buf[15:0] !== 16'h3231 || entry_len !== LW'(2)) begin
            errors++;
            $display("[TB] FAIL basic_line: cv=%0d buf=%h len=%0d, required 2 3231 2", cv_cnt - cv0, entry_buf[15:0], entry_len);
        end
    endtask

    task automatic test_backspace_enter();
        send_byte(8'h66); send_byte(8'hF0); send_byte(8'h66);
        checks++;
        if (entry_len !== LW'(1) || entry_buf[15:8] !== 8'h00 || entry_buf[7:0] !== 8'h31) begin
            errors++;
            $display("[TB] FAIL backspace: len=%0d buf=%h, required 1 0031", entry_len, entry_buf[15:0]);
        end
        @(posedge clk); #1;
        rx_data = 8'h5A;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (entry_done !== 1'b1 || entry_buf[7:0] !== 8'h31 || entry_len !== LW'(1)) begin
            errors++;
            $display("[TB] FAIL enter_commit: done=%b buf=%h len=%0d, required 1 31 1", entry_done, entry_buf[7:0], entry_len);
        end
        @(posedge clk); #1;
        checks++;
        if (entry_done !== 1'b0 || entry_len !== '0 || entry_buf !== '0) begin
            errors++;
            $display("[TB] FAIL enter_clear: done=%b len=%0d buf=%h, required 0 0 0", entry_done, entry_len, entry_buf);
        end
        send_byte(8'hF0); send_byte(8'h5A);
    endtask

    task automatic test_overflow();
        logic [7:0] digits [9];
        int cv0, ov0, d0;
        digits = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        cv0 = cv_cnt;
        ov0 = ov_cnt;
        for (int i = 0; i < 9; i++) send_byte(digits[i]);
        checks++;
        if (cv_cnt - cv0 !== 8 || ov_cnt - ov0 !== 1 || entry_len !== LW'(8)) begin
            errors++;
            $display("[TB] FAIL overflow_counts: cv=%0d ov=%0d len=%0d, required 8 1 8", cv_cnt - cv0, ov_cnt - ov0, entry_len);
        end
        checks++;
        if (entry_buf !== 64'h3837363534333231) begin
            errors++;
            $display("[TB] FAIL overflow_buf: buf=%h, required 3837363534333231", entry_buf);
        end
        d0 = done_cnt;
        send_byte(8'h5A); send_byte(8'hF0); send_byte(8'h5A);
        checks++;
        if (done_cnt - d0 !== 1 || entry_len !== '0) begin
            errors++;
            $display("[TB] FAIL full_commit: done=%0d len=%0d, required 1 0", done_cnt - d0, entry_len);
        end
        d0 = done_cnt;
        send_byte(8'h5A); send_byte(8'hF0); send_byte(8'h5A);
        send_byte(8'h66); send_byte(8'hF0); send_byte(8'h66);
        checks++;
        if (done_cnt - d0 !== 0 || entry_len !== '0) begin
            errors++;
            $display("[TB] FAIL empty_enter_bs: done=%0d len=%0d, required 0 0", done_cnt - d0, entry_len);
        end
    endtask

    task automatic test_ignored();
        int cv0, ov0, d0;
        cv0 = cv_cnt; ov0 = ov_cnt; d0 = done_cnt;
        send_byte(8'h16); send_byte(8'hF0); send_byte(8'h16);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'h05); send_byte(8'h0D);
        checks++;
        if (cv_cnt - cv0 !== 1 || ov_cnt - ov0 !== 0 || done_cnt - d0 !== 0) begin
            errors++;
            $display("[TB] FAIL ignored_pulses: cv=%0d ov=%0d done=%0d, required 1 0 0", cv_cnt - cv0, ov_cnt - ov0, done_cnt - d0);
        end
        checks++;
        if (entry_len !== LW'(1) || entry_buf !== 64'h31) begin
            errors++;
            $display("[TB] FAIL ignored_buf: len=%0d buf=%h, required 1 31", entry_len, entry_buf);
        end
    endtask

    task automatic test_clear_collision();
        int cv0;
        cv0 = cv_cnt;
        @(posedge clk); #1;
        rx_data = 8'h2E;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++;
        if (char_valid !== 1'b0 || entry_len !== '0 || entry_buf !== '0) begin
            errors++;
            $display("[TB] FAIL clear_collision: cv=%b len=%0d buf=%h, required 0 0 0", char_valid, entry_len, entry_buf);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (cv_cnt - cv0 !== 0) begin
            errors++;
            $display("[TB] FAIL clear_no_char: cv=%0d, required 0", cv_cnt - cv0);
        end
        send_byte(8'hF0); send_byte(8'h2E);
    endtask

    task automatic test_reset_mid();
        send_byte(8'hF0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send_byte(8'h45);
        checks++;
        if (char_out !== 8'h30 || entry_len !== LW'(1) || entry_buf !== 64'h30) begin
            errors++;
            $display("[TB] FAIL reset_mid: char=%h len=%0d buf=%h, required 30 1 30", char_out, entry_len, entry_buf);
        end
    endtask

    task automatic test_typematic();
        int cv0, exp_n;
`ifdef TYPEMATIC_FILTER_EN
        exp_n = 2;
`else
        exp_n = 4;
`endif
        pulse_clear();
        cv0 = cv_cnt;
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
        checks++;
        if (cv_cnt - cv0 !== exp_n || entry_len !== LW'(exp_n) || entry_buf[7:0] !== 8'h61) begin
            errors++;
            $display("[TB] FAIL typematic: cv=%0d len=%0d slot0=%h, required %0d %0d 61", cv_cnt - cv0, entry_len, entry_buf[7:0], exp_n, exp_n);
        end
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_backspace_enter();
        test_overflow();
        test_ignored();
        test_clear_collision();
        test_reset_mid();
        test_typematic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
